// File: rtl/code_lock_dialer.sv
// Replays a stored multi-digit decimal code as 4-bit strobes, MSD first,
// with a programmable gap before each digit.
module code_lock_dialer #(
  parameter int p_divider = 17_865_771,
  parameter int p_digits  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_value [p_digits-1:0],
  input  logic       i_start,
  input  logic       i_abort,
  output logic [3:0] o_code,
  output logic       o_code_vld,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int DW = $clog2(p_divider + 1);
  localparam int IW = (p_digits > 1) ? $clog2(p_digits) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(p_divider - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(p_digits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [3:0]    r_snap [p_digits-1:0];
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_div;
  logic [3:0]    r_code;
  logic          r_vld;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < p_digits; i++) begin
      if (i_value[i] > 4'd9) w_bad = 1'b1;
    end
  end

  // Outputs are registered against the state being entered,
  // so each pulse lines up with the cycle spent in that state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_snap  <= '{default: '0};
      r_idx   <= '0;
      r_div   <= '0;
      r_code  <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_code <= '0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_div   <= '0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_bad) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end else begin
                r_state <= S_WAIT;
                r_snap  <= i_value;
                r_idx   <= IDX_TOP;
                r_div   <= '0;
                r_busy  <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (r_div == DIV_LAST) begin
              r_state <= S_SEND;
              r_vld   <= 1'b1;
              r_code  <= r_snap[r_idx];
            end else begin
              r_div <= r_div + DW'(1);
            end
          end
          S_SEND: begin
            if (r_idx == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_idx   <= r_idx - IW'(1);
              r_div   <= '0;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          S_ERR: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_code     = r_code;
  assign o_code_vld = r_vld;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_code_lock_dialer.sv
// Bench for code_lock_dialer: directed scenarios plus random traffic,
// checked cycle by cycle against an arithmetic schedule model.
module tb_code_lock_dialer;

  localparam int D = 3;
  localparam int N = 4;
  localparam int PER = D + 1;
  localparam int TOT = N * PER + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] val [N-1:0];
  logic       start;
  logic       abort;
  logic [3:0] code;
  logic       vld;
  logic       busy;
  logic       done;
  logic       err;

  logic       e_rst;
  logic [3:0] e_val [0:0];
  logic       e_start;
  logic       e_abort;
  logic [3:0] e_code;
  logic       e_vld;
  logic       e_busy;
  logic       e_done;
  logic       e_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit         m_active = 1'b0;
  int         m_t0     = 0;
  int         m_errc   = -1;
  logic [3:0] m_dig [N];

  always #5 clk = ~clk;

  code_lock_dialer #(.p_divider(D), .p_digits(N)) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_value   (val),
    .i_start   (start),
    .i_abort   (abort),
    .o_code    (code),
    .o_code_vld(vld),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  code_lock_dialer #(.p_divider(1), .p_digits(1)) u_edge (
    .i_clk     (clk),
    .i_rst     (e_rst),
    .i_value   (e_val),
    .i_start   (e_start),
    .i_abort   (e_abort),
    .o_code    (e_code),
    .o_code_vld(e_vld),
    .o_busy    (e_busy),
    .o_done    (e_done),
    .o_err     (e_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check this cycle's outputs, advance model.
  task automatic step(input bit st, input bit ab, input bit rs,
                      input logic [15:0] pv);
    int  rel;
    bit  x_busy, x_vld, x_done, x_err, bad;
    logic [3:0] x_code;
    start = st;
    abort = ab;
    rst   = rs;
    for (int i = 0; i < N; i++) val[i] = pv[4*i +: 4];
    rel    = cyc - m_t0;
    x_busy = m_active && rel >= 1 && rel <= TOT;
    x_vld  = x_busy && (rel % PER == 0) && rel <= N * PER;
    x_code = x_vld ? m_dig[N - rel / PER] : 4'd0;
    x_done = x_busy && rel == TOT;
    x_err  = (cyc == m_errc);
    chk("busy", {7'd0, busy}, {7'd0, x_busy});
    chk("vld",  {7'd0, vld},  {7'd0, x_vld});
    chk("code", {4'd0, code}, {4'd0, x_code});
    chk("done", {7'd0, done}, {7'd0, x_done});
    chk("err",  {7'd0, err},  {7'd0, x_err});
    if (!rs) begin
      m_active = 1'b0;
      m_errc   = -1;
    end else if (ab) begin
      m_active = 1'b0;
    end else if (st && !x_busy && !x_err) begin
      bad = 1'b0;
      for (int i = 0; i < N; i++) if (pv[4*i +: 4] > 4'd9) bad = 1'b1;
      if (bad) begin
        m_errc   = cyc + 1;
        m_active = 1'b0;
      end else begin
        m_active = 1'b1;
        m_t0     = cyc;
        for (int i = 0; i < N; i++) m_dig[i] = pv[4*i +: 4];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  initial begin
    logic [15:0] rv;
    e_rst = 1'b0; e_start = 1'b0; e_abort = 1'b0; e_val[0] = 4'd7;
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    for (int i = 0; i < N; i++) val[i] = 4'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h1905);
    e_rst = 1'b1;
    idle(3);

    // nominal 1,9,0,5
    step(1'b1, 1'b0, 1'b1, 16'h1905);
    idle(22);
    // bad digit d1=12
    step(1'b1, 1'b0, 1'b1, 16'h19C5);
    idle(6);
    // abort at cycle 9
    step(1'b1, 1'b0, 1'b1, 16'h1905);
    idle(8);
    step(1'b0, 1'b1, 1'b1, 16'h1905);
    idle(12);
    // ignored restart and value change mid-transfer
    step(1'b1, 1'b0, 1'b1, 16'h1905);
    idle(5);
    step(1'b1, 1'b0, 1'b1, 16'h8888);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 16'h8888);
    // reset at cycle 5, then full rerun
    step(1'b1, 1'b0, 1'b1, 16'h1905);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 16'h1905);
    idle(4);
    step(1'b1, 1'b0, 1'b1, 16'h1905);
    idle(20);
    // abort and start together in idle
    step(1'b1, 1'b1, 1'b1, 16'h4321);
    idle(3);

    // edge instance: p_divider=1, p_digits=1, d0=7
    e_start = 1'b1;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    e_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("e_busy", {7'd0, e_busy}, {7'd0, (c <= 3)});
      chk("e_vld",  {7'd0, e_vld},  {7'd0, (c == 2)});
      chk("e_code", {4'd0, e_code}, (c == 2) ? 8'd7 : 8'd0);
      chk("e_done", {7'd0, e_done}, {7'd0, (c == 3)});
      chk("e_err",  {7'd0, e_err},  8'd0);
      step(1'b0, 1'b0, 1'b1, 16'h0000);
    end

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 15) == 0)
          rv[4*d +: 4] = 4'($urandom_range(10, 15));
        else
          rv[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      step($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 149) != 0, rv);
    end
    idle(TOT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
